// File: rtl/instruction_sequencer_if.sv
// Instruction-fetch bus between the sequencer and instruction memory.
//   mem_req   : fetch request, held until acknowledged
//   mem_addr  : fetch address (the sequencer's current PC)
//   mem_ack   : mem_rdata is valid this cycle
//   mem_rdata : fetched instruction word
// The master modport is the sequencer side, the slave modport is the memory side.
interface instruction_sequencer_if #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16
);
  logic                   mem_req;
  logic [PC_WIDTH-1:0]    mem_addr;
  logic                   mem_ack;
  logic [INSTR_WIDTH-1:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/instruction_sequencer.sv
// Multi-cycle fetch/decode/execute controller for the 16-bit datapath.
// Fetches words over the mem bus, drives the instruction-register load
// (IL/IR), sequences the ALU (alu_start/alu_done) and register-file write
// (RW/wr_addr) from the decoded fields, and owns the program counter.
// Ports:
//   clk, reset       : clock; asynchronous active-low reset
//   mem              : fetch bus (master side)
//   IL, IR           : instruction-register load strobe and word
//   opcode/DA/AA/BA  : decoded fields returned by the instruction register
//   alu_start        : one-cycle ALU start; alu_done : ALU result valid
//   RW, wr_addr      : register-file write pulse and address
//   pc, halted       : program counter, stopped on HALT
//   instr_count      : retired-instruction counter (wraps)
module instruction_sequencer #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  instruction_sequencer_if.master mem,
  output logic                   IL,
  output logic [INSTR_WIDTH-1:0] IR,
  input  logic [3:0]             opcode,
  input  logic [3:0]             DA,
  input  logic [3:0]             AA,
  input  logic [3:0]             BA,
  output logic                   alu_start,
  input  logic                   alu_done,
  output logic                   RW,
  output logic [3:0]             wr_addr,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   halted,
  output logic [15:0]            instr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_SETTLE, S_DECODE, S_EXEC, S_WRITEBACK, S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t state, state_next;
  logic   alu_issued;   // set once the first EXEC cycle has passed
  logic   retire;
  logic [7:0]          jmp_field;
  logic [PC_WIDTH-1:0] jmp_target;

  // The {AA,BA} target is zero-extended or truncated to the PC width.
  assign jmp_field  = {AA, BA};
  assign jmp_target = PC_WIDTH'(jmp_field);
  assign mem.mem_addr = pc;

  // Next state and strobes. Strobes are pure state decodes, so at most one
  // of mem_req/IL/alu_start/RW can be high in any cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // left one unassigned would infer a latch.
    state_next  = state;
    mem.mem_req = 1'b0;
    IL          = 1'b0;
    alu_start   = 1'b0;
    RW          = 1'b0;
    halted      = 1'b0;
    retire      = 1'b0;
    case (state)
      S_IDLE:   state_next = S_FETCH;
      S_FETCH: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ack) state_next = S_LOAD;
      end
      S_LOAD: begin
        IL         = 1'b1;
        state_next = S_SETTLE;
      end
      S_SETTLE: state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_NOP, OP_JMP: begin
            retire     = 1'b1;
            state_next = S_FETCH;
          end
          OP_HALT: begin
            retire     = 1'b1;
            state_next = S_HALT;
          end
          default: state_next = S_EXEC;
        endcase
      end
      S_EXEC: begin
        alu_start = !alu_issued;
        // alu_done counts even in the cycle that issues alu_start.
        if (alu_done) state_next = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        RW         = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT:   halted = 1'b1;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      alu_issued  <= 1'b0;
      pc          <= '0;
      IR          <= '0;
      wr_addr     <= '0;
      instr_count <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state      <= state_next;
      alu_issued <= (state == S_EXEC);
      if (state == S_FETCH && mem.mem_ack) begin
        IR <= mem.mem_rdata;
        pc <= pc + PC_WIDTH'(1);
      end
      if (state == S_DECODE) begin
        wr_addr <= DA;
        // Overrides the post-increment done at fetch.
        if (opcode == OP_JMP) pc <= jmp_target;
      end
      if (retire) instr_count <= instr_count + 16'd1;
    end
  end

endmodule
